and_bist_driver: RTL and testbench

- Synthesizable self-checking initiator for the two-input AND responder (and2) on the and_if interface.
- On a start request it drives a fixed-length sequence of A/B vectors into the responder and aligns the expected result to the responder's output latency.
- It compares the responder output Y against A&B for every vector and reports pass/fail, an error count and the first failing vector index.
- Sits beside the responder in the harness as an RTL alternative to the class-based agent: hardware BIST, usable without the OVM environment.

---
 rtl/and_bist_driver_if.sv | 16 +
 rtl/and_bist_driver.sv | 158 +++++++++++++++
 tb/tb_and_bist_driver.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/and_bist_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : and_bist_driver_if
// Description : Operand/result bundle between the BIST driver and the and2
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface and_bist_driver_if;
    logic A;
    logic B;
    logic Y;

    modport master (output A, output B, input Y);
    modport slave  (input A, input B, output Y);
endinterface
`default_nettype wire

// File: rtl/and_bist_driver.sv
`default_nettype none
// ============================================================================
// Module      : and_bist_driver
// Description : Hardware BIST initiator for the and2 responder. It drives a
//               run of A/B vectors and checks Y against a latency-aligned A&B.
// Revision    : 1.0 - initial release
// ============================================================================
module and_bist_driver #(
    parameter int NUM_VECTORS = 16,
    parameter int DUV_LATENCY = 1,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [7:0]            seed,
    and_bist_driver_if.master     bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [IDX_W-1:0]      first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_VECTORS - 1);
    localparam logic [3:0]       c_drain_last = 4'(DUV_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_mode;
    logic [7:0]         r_lfsr;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_drain_cnt;
    logic               r_a;
    logic               r_b;
    logic               r_pv [DUV_LATENCY];
    logic               r_pe [DUV_LATENCY];
    logic [IDX_W-1:0]   r_pi [DUV_LATENCY];

    logic [7:0]         w_seed_nz;
    logic [7:0]         w_lfsr_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic               w_mismatch;
    logic [CNT_W-1:0]   w_err_next;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    assign w_seed_nz   = (seed == 8'h00) ? 8'h01 : seed;
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_idx_next  = r_idx + IDX_W'(1);
    assign w_mismatch  = r_pv[DUV_LATENCY-1] && (bus.Y != r_pe[DUV_LATENCY-1]);
    assign w_err_next  = (w_mismatch && (err_cnt != c_cnt_max)) ? err_cnt + CNT_W'(1) : err_cnt;

    assign bus.A = r_a;
    assign bus.B = r_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_DRIVE;
            S_DRIVE: begin
                busy = 1'b1;
                if (r_idx == c_last_idx) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == c_drain_last) w_state_next = S_DONE;
            end
            default: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode        <= 1'b0;
            r_lfsr        <= 8'h01;
            r_idx         <= '0;
            r_drain_cnt   <= '0;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            for (int i = 0; i < DUV_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pi[i] <= '0;
            end
        end else begin
            // Expected-result pipeline: the tail lines up with the responder's Y.
            r_pv[0] <= (r_state == S_DRIVE);
            r_pe[0] <= r_a & r_b;
            r_pi[0] <= r_idx;
            for (int i = 1; i < DUV_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pi[i] <= r_pi[i-1];
            end

            if (w_mismatch) begin
                err_cnt <= w_err_next;
                if (err_cnt == '0) first_err_idx <= r_pi[DUV_LATENCY-1];
            end

            case (r_state)
                S_IDLE: if (start) begin
                    r_mode        <= mode;
                    r_lfsr        <= w_seed_nz;
                    r_idx         <= '0;
                    err_cnt       <= '0;
                    first_err_idx <= '0;
                    pass          <= 1'b0;
                    r_a           <= mode ? w_seed_nz[0] : 1'b0;
                    r_b           <= mode ? w_seed_nz[1] : 1'b0;
                end
                S_DRIVE: begin
                    if (r_idx == c_last_idx) begin
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_idx  <= w_idx_next;
                        r_lfsr <= w_lfsr_next;
                        r_a    <= r_mode ? w_lfsr_next[0] : w_idx_next[0];
                        r_b    <= r_mode ? w_lfsr_next[1] : w_idx_next[1];
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 4'd1;
                    // Result includes the compare happening on this same edge.
                    if (r_drain_cnt == c_drain_last) pass <= (w_err_next == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_and_bist_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_bist_driver
// Description : Directed self-checking bench for and_bist_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_and_bist_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Main instance: latency 1, registered and2 responder with fault select.
    logic       start_m = 1'b0;
    logic       mode_m  = 1'b0;
    logic [7:0] seed_m  = 8'h00;
    logic       busy_m, done_m, pass_m;
    logic [7:0] err_m, fidx_m;
    int         y_sel   = 0;
    logic       y_reg_m = 1'b0;
    and_bist_driver_if if_m ();

    and_bist_driver #(.NUM_VECTORS(16), .DUV_LATENCY(1), .CNT_W(8), .IDX_W(8)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .mode(mode_m), .seed(seed_m), .bus(if_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_cnt(err_m), .first_err_idx(fidx_m));

    always @(posedge clk) y_reg_m <= if_m.A & if_m.B;
    assign if_m.Y = (y_sel == 1) ? 1'b0 : (y_sel == 2) ? 1'b1 : y_reg_m;

    // Auxiliary instances share one start: saturation, latency 3, misaligned latency 2.
    logic       start_x = 1'b0;
    logic       busy_s, done_s, pass_s, busy_3, done_3, pass_3, busy_2, done_2, pass_2;
    logic [1:0] err_s;
    logic [7:0] fidx_s, err_3, fidx_3, err_2, fidx_2;
    logic [2:0] d3 = 3'b000;
    logic [2:0] d2 = 3'b000;
    and_bist_driver_if if_s ();
    and_bist_driver_if if_3 ();
    and_bist_driver_if if_2 ();

    and_bist_driver #(.NUM_VECTORS(16), .DUV_LATENCY(1), .CNT_W(2), .IDX_W(8)) dut_s (
        .clk(clk), .rst(rst), .start(start_x), .mode(1'b0), .seed(8'h00), .bus(if_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s), .first_err_idx(fidx_s));
    and_bist_driver #(.NUM_VECTORS(16), .DUV_LATENCY(3), .CNT_W(8), .IDX_W(8)) dut_3 (
        .clk(clk), .rst(rst), .start(start_x), .mode(1'b0), .seed(8'h00), .bus(if_3),
        .busy(busy_3), .done(done_3), .pass(pass_3), .err_cnt(err_3), .first_err_idx(fidx_3));
    and_bist_driver #(.NUM_VECTORS(16), .DUV_LATENCY(2), .CNT_W(8), .IDX_W(8)) dut_2 (
        .clk(clk), .rst(rst), .start(start_x), .mode(1'b0), .seed(8'h00), .bus(if_2),
        .busy(busy_2), .done(done_2), .pass(pass_2), .err_cnt(err_2), .first_err_idx(fidx_2));

    assign if_s.Y = 1'b1;
    always @(posedge clk) begin
        d3 <= {d3[1:0], if_3.A & if_3.B};
        d2 <= {d2[1:0], if_2.A & if_2.B};
    end
    assign if_3.Y = d3[2];
    assign if_2.Y = d2[2];

    logic [1:0] ab_log [16];   // {B,A} seen in each DRIVE cycle
    int         done_at;

    task automatic run_main();
        done_at = 0;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 16) ab_log[k-1] = {if_m.B, if_m.A};
            if (done_m) done_at = k;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({if_m.A, if_m.B, busy_m, done_m, pass_m} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_bits: got %b expected 00000", {if_m.A, if_m.B, busy_m, done_m, pass_m});
        end
        tests_run++;
        if (err_m !== 8'd0 || fidx_m !== 8'd0) begin
            tests_failed++; $display("FAIL reset_counts: got err=%0d idx=%0d expected 0 0", err_m, fidx_m);
        end
        rst = 1'b0;
    endtask

    task automatic test_mode0_good();
        logic [1:0] e;
        y_sel = 0; mode_m = 1'b0;
        run_main();
        for (int i = 0; i < 16; i++) begin
            e = 2'(i);
            tests_run++;
            if (ab_log[i] !== e) begin
                tests_failed++; $display("FAIL mode0_vec%0d: got BA=%b expected %b", i, ab_log[i], e);
            end
        end
        tests_run++;
        if (done_at != 18) begin
            tests_failed++; $display("FAIL mode0_done_time: got %0d expected 18", done_at);
        end
        tests_run++;
        if (pass_m !== 1'b1 || err_m !== 8'd0 || fidx_m !== 8'd0) begin
            tests_failed++; $display("FAIL mode0_result: got pass=%b err=%0d idx=%0d expected 1 0 0", pass_m, err_m, fidx_m);
        end
    endtask

    task automatic test_stuck();
        y_sel = 1;
        run_main();
        tests_run++;
        if (pass_m !== 1'b0 || err_m !== 8'd4 || fidx_m !== 8'd3) begin
            tests_failed++; $display("FAIL stuck0_result: got pass=%b err=%0d idx=%0d expected 0 4 3", pass_m, err_m, fidx_m);
        end
        y_sel = 2;
        run_main();
        tests_run++;
        if (pass_m !== 1'b0 || err_m !== 8'd12 || fidx_m !== 8'd0) begin
            tests_failed++; $display("FAIL stuck1_result: got pass=%b err=%0d idx=%0d expected 0 12 0", pass_m, err_m, fidx_m);
        end
        y_sel = 0;
    endtask

    task automatic test_saturation();
        @(negedge clk); start_x = 1'b1;
        @(negedge clk); start_x = 1'b0;
        repeat (30) @(negedge clk);
        tests_run++;
        if (pass_s !== 1'b0 || err_s !== 2'd3 || fidx_s !== 8'd0) begin
            tests_failed++; $display("FAIL sat_result: got pass=%b err=%0d idx=%0d expected 0 3 0", pass_s, err_s, fidx_s);
        end
    endtask

    task automatic test_mode1_lfsr();
        y_sel = 0; mode_m = 1'b1; seed_m = 8'h00;
        run_main();
        tests_run++;
        if (ab_log[0] !== 2'b01 || ab_log[1] !== 2'b10 || ab_log[2] !== 2'b00) begin
            tests_failed++; $display("FAIL lfsr_vectors: got BA=%b,%b,%b expected 01,10,00", ab_log[0], ab_log[1], ab_log[2]);
        end
        tests_run++;
        if (pass_m !== 1'b1 || err_m !== 8'd0) begin
            tests_failed++; $display("FAIL lfsr_result: got pass=%b err=%0d expected 1 0", pass_m, err_m);
        end
        mode_m = 1'b0;
    endtask

    task automatic test_latency();
        int t3 = 0;
        @(negedge clk); start_x = 1'b1;
        @(negedge clk); start_x = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done_3 && t3 == 0) t3 = k;
        end
        tests_run++;
        if (t3 != 20) begin
            tests_failed++; $display("FAIL lat3_done_time: got %0d expected 20", t3);
        end
        tests_run++;
        if (pass_3 !== 1'b1 || err_3 !== 8'd0) begin
            tests_failed++; $display("FAIL lat3_result: got pass=%b err=%0d expected 1 0", pass_3, err_3);
        end
        tests_run++;
        if (pass_2 !== 1'b0 || err_2 !== 8'd7 || fidx_2 !== 8'd3) begin
            tests_failed++; $display("FAIL lat2_misalign: got pass=%b err=%0d idx=%0d expected 0 7 3", pass_2, err_2, fidx_2);
        end
    endtask

    task automatic test_reset_midrun();
        int busy_seen = 0;
        int done_seen = 0;
        y_sel = 1;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (err_m !== 8'd1 || {if_m.B, if_m.A} !== 2'b01) begin
            tests_failed++; $display("FAIL midrun_pre: got err=%0d BA=%b expected 1 01", err_m, {if_m.B, if_m.A});
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({if_m.A, if_m.B, busy_m, done_m, pass_m} !== 5'b0 || err_m !== 8'd0 || fidx_m !== 8'd0) begin
            tests_failed++; $display("FAIL midrun_async_clear: got bits=%b err=%0d idx=%0d expected 00000 0 0",
                                     {if_m.A, if_m.B, busy_m, done_m, pass_m}, err_m, fidx_m);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy_m) busy_seen++;
            if (done_m) done_seen++;
        end
        tests_run++;
        if (busy_seen != 0 || done_seen != 0) begin
            tests_failed++; $display("FAIL midrun_idle_after: got busy=%0d done=%0d cycles expected 0 0", busy_seen, done_seen);
        end
        y_sel = 0;
    endtask

    task automatic test_start_ignored();
        int first_done = 0;
        int done_cnt   = 0;
        int bad_vec    = 0;
        logic [1:0] e;
        @(negedge clk); start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        ab_log[0] = {if_m.B, if_m.A};
        for (int k = 2; k <= 50; k++) begin
            @(negedge clk);
            start_m = (k == 5 || k == 18);
            if (k <= 16) ab_log[k-1] = {if_m.B, if_m.A};
            if (done_m) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
        end
        start_m = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = 2'(i);
            if (ab_log[i] !== e) bad_vec++;
        end
        tests_run++;
        if (first_done != 18 || done_cnt != 1) begin
            tests_failed++; $display("FAIL ignore_start_done: got at=%0d count=%0d expected 18 1", first_done, done_cnt);
        end
        tests_run++;
        if (bad_vec != 0 || pass_m !== 1'b1) begin
            tests_failed++; $display("FAIL fresh_run: got bad_vectors=%0d pass=%b expected 0 1", bad_vec, pass_m);
        end
    endtask

    task automatic test_back_to_back();
        logic b19, b20;
        int   second = 0;
        @(negedge clk); start_m = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 19) b19 = busy_m;
            if (k == 20) b20 = busy_m;
        end
        start_m = 1'b0;
        for (int k = 21; k <= 45 && second == 0; k++) begin
            @(negedge clk);
            if (done_m) second = k;
        end
        tests_run++;
        if (b19 !== 1'b0 || b20 !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_gap: got busy@19=%b busy@20=%b expected 0 1", b19, b20);
        end
        tests_run++;
        if (second != 37) begin
            tests_failed++; $display("FAIL b2b_second_done: got %0d expected 37", second);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_good();
        test_stuck();
        test_saturation();
        test_mode1_lfsr();
        test_latency();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
